hpi_bus_master: RTL and testbench



---
 rtl/hpi_pkg.sv | 31 +++
 rtl/hpi_bus_master_if.sv | 39 +++
 rtl/hpi_tristate.sv | 15 +
 rtl/hpi_bus_master.sv | 168 ++++++++++++++++
 tb/tb_hpi_bus_master.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hpi_pkg.sv
// Shared types and default timing for the HPI bus master.
// Imported by the interface and every HPI module.
package hpi_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } hpi_state_e;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 1;
    localparam int DEF_RST_CYC    = 4;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hpi_bus_master_if.sv
// Request/response handshake between the register bridge and the HPI master.
// The bridge uses the master modport, the transaction engine the slave.
interface hpi_bus_master_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output busy
    );

endinterface

// File: rtl/hpi_tristate.sv
// Bidirectional OTG data pad: registered data drives the bus only when
// enabled; the resolved bus value is always returned for read capture.
module hpi_tristate #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data,
    input  logic              oe,
    inout  wire  [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] sample
);

    assign bus    = oe ? data : {DATA_W{1'bz}};
    assign sample = bus;

endmodule

// File: rtl/hpi_bus_master.sv
// HPI transaction engine: OTG chip reset pulse after system reset, then
// request/response cycles with programmable setup, strobe and hold timing.
module hpi_bus_master
    import hpi_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int RST_CYC    = DEF_RST_CYC
) (
    input  logic              Clk,
    input  logic              Reset_N,
    hpi_bus_master_if.slave   req,
    inout  wire  [DATA_W-1:0] OTG_DATA,
    output logic [ADDR_W-1:0] OTG_ADDR,
    output logic              OTG_RD_N,
    output logic              OTG_WR_N,
    output logic              OTG_CS_N,
    output logic              OTG_RST_N
);

    localparam int CNT_MAX = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);

    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || RST_CYC < 1)
    begin : g_bad_cyc
        $error("hpi_bus_master: every *_CYC parameter must be >= 1");
    end

    hpi_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rst_n_q, rst_n_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              drive_en_q, drive_en_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic              rsp_q, rsp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] bus_in;

    hpi_tristate #(.DATA_W(DATA_W)) u_tri (
        .data   (wdata_q),
        .oe     (drive_en_q),
        .bus    (OTG_DATA),
        .sample (bus_in)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q    <= BOOT;
            cnt_q      <= '0;
            rst_n_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            addr_q     <= '0;
            drive_en_q <= 1'b0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            rsp_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_n_q    <= rst_n_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            addr_q     <= addr_d;
            drive_en_q <= drive_en_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            rsp_q      <= rsp_d;
            rdata_q    <= rdata_d;
        end
    end

    // Counter restarts from zero on every state change.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        rst_n_d    = rst_n_q;
        cs_n_d     = cs_n_q;
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        addr_d     = addr_q;
        drive_en_d = drive_en_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        rsp_d      = 1'b0;
        rdata_d    = rdata_q;
        unique case (state_q)
            BOOT: begin
                if (cnt_q == RST_LAST) begin
                    rst_n_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (req.req_valid) begin
                    addr_d     = req.req_addr;
                    is_wr_d    = req.req_write;
                    wdata_d    = req.req_wdata;
                    cs_n_d     = 1'b0;
                    drive_en_d = req.req_write;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    rd_n_d  = is_wr_q;
                    wr_n_d  = !is_wr_q;
                    state_d = STROBE;
                    cnt_d   = '0;
                end
            end
            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    if (!is_wr_q) rdata_d = bus_in;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cs_n_d     = 1'b1;
                    drive_en_d = 1'b0;
                    rsp_d      = 1'b1;
                    state_d    = RESP;
                    cnt_d      = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = BOOT;
                cnt_d   = '0;
            end
        endcase
    end

    assign OTG_ADDR      = addr_q;
    assign OTG_RD_N      = rd_n_q;
    assign OTG_WR_N      = wr_n_q;
    assign OTG_CS_N      = cs_n_q;
    assign OTG_RST_N     = rst_n_q;
    assign req.req_ready = (state_q == IDLE);
    assign req.busy      = (state_q != IDLE);
    assign req.rsp_valid = rsp_q;
    assign req.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_hpi_bus_master.sv
// Bench for hpi_bus_master: default instance plus a wide, slow-timing one,
// with response data tracked through per-instance scoreboard queues.
module tb_hpi_bus_master;

    logic Clk = 1'b0;
    logic Reset_N;

    always #5 Clk = ~Clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    hpi_bus_master_if #(.DATA_W(16), .ADDR_W(2)) m1 ();
    hpi_bus_master_if #(.DATA_W(32), .ADDR_W(3)) m2 ();

    wire  [15:0] otg_data1;
    logic [1:0]  otg_addr1;
    logic        rd_n1, wr_n1, cs_n1, rst_n1;
    logic [15:0] bus_val1 = 16'h0;

    wire  [31:0] otg_data2;
    logic [2:0]  otg_addr2;
    logic        rd_n2, wr_n2, cs_n2, rst_n2;

    // OTG chip model: answers reads only while selected and RD_N is low.
    assign otg_data1 = (!rd_n1 && !cs_n1) ? bus_val1 : 16'hzzzz;
    assign otg_data2 = (!rd_n2 && !cs_n2) ? 32'h0 : 32'hzzzz_zzzz;

    hpi_bus_master dut1 (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .req       (m1),
        .OTG_DATA  (otg_data1),
        .OTG_ADDR  (otg_addr1),
        .OTG_RD_N  (rd_n1),
        .OTG_WR_N  (wr_n1),
        .OTG_CS_N  (cs_n1),
        .OTG_RST_N (rst_n1)
    );

    hpi_bus_master #(
        .DATA_W(32), .ADDR_W(3), .SETUP_CYC(2),
        .STROBE_CYC(5), .HOLD_CYC(3), .RST_CYC(4)
    ) dut2 (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .req       (m2),
        .OTG_DATA  (otg_data2),
        .OTG_ADDR  (otg_addr2),
        .OTG_RD_N  (rd_n2),
        .OTG_WR_N  (wr_n2),
        .OTG_CS_N  (cs_n2),
        .OTG_RST_N (rst_n2)
    );

    logic [15:0] sb1[$];
    logic [31:0] sb2[$];
    logic [15:0] last1 = 16'h0;

    always @(negedge Clk) begin
        if (m1.rsp_valid) begin
            if (sb1.size() == 0) chk("sb1_spurious_rsp", 1, 0);
            else chk("sb1_rdata", m1.rsp_rdata, sb1.pop_front());
        end
        if (m2.rsp_valid) begin
            if (sb2.size() == 0) chk("sb2_spurious_rsp", 1, 0);
            else chk("sb2_rdata", m2.rsp_rdata, sb2.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1, "timeout");
    end

    // Called on a negedge while reset is asserted; releases it there.
    task automatic boot_seq();
        int n = 0;
        int bad = 0;
        Reset_N = 1'b1;
        while (rst_n1 == 1'b0 && n < 50) begin
            n++;
            if (!rd_n1 || !wr_n1 || !cs_n1 || dut1.drive_en_q) bad++;
            if (m1.req_ready) bad++;
            @(negedge Clk);
        end
        chk("boot_rst_cyc", n, 4);
        chk("boot_bus_quiet", bad, 0);
        chk("boot_ready", m1.req_ready, 1);
        chk("boot_rst2", rst_n2, 1);
    endtask

    task automatic txn1(input logic wr, input logic [1:0] a,
                        input logic [15:0] d);
        int n = 0;
        int cs_bad = 0, st_lo = 0, st_bad = 0, oth_lo = 0;
        int rv_at = 0, rv_n = 0, dat_bad = 0, drv_bad = 0, adr_bad = 0;
        logic st, oth;
        while (!m1.req_ready && n < 50) begin
            n++;
            @(negedge Clk);
        end
        chk(wr ? "wr_ready" : "rd_ready", m1.req_ready, 1);
        m1.req_valid = 1'b1;
        m1.req_write = wr;
        m1.req_addr  = a;
        m1.req_wdata = wr ? d : 16'h0;
        bus_val1     = wr ? 16'h0 : d;
        if (wr) sb1.push_back(last1);
        else begin
            sb1.push_back(d);
            last1 = d;
        end
        @(negedge Clk);
        m1.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            st  = wr ? wr_n1 : rd_n1;
            oth = wr ? rd_n1 : wr_n1;
            if (!cs_n1 != (k <= 4)) cs_bad++;
            if (!st) begin
                st_lo++;
                if (k < 2 || k > 3) st_bad++;
            end
            if (!oth) oth_lo++;
            if (m1.rsp_valid) begin
                rv_at = k;
                rv_n++;
            end
            if (wr && !cs_n1 && otg_data1 !== d) dat_bad++;
            if (!cs_n1 && otg_addr1 != a) adr_bad++;
            if (dut1.drive_en_q != (wr && !cs_n1)) drv_bad++;
            @(negedge Clk);
        end
        chk(wr ? "wr_cs_window" : "rd_cs_window", cs_bad, 0);
        chk(wr ? "wr_strobe_len" : "rd_strobe_len", st_lo, 2);
        chk(wr ? "wr_strobe_pos" : "rd_strobe_pos", st_bad, 0);
        chk(wr ? "wr_other_strobe" : "rd_other_strobe", oth_lo, 0);
        chk(wr ? "wr_rsp_at" : "rd_rsp_at", rv_at, 5);
        chk(wr ? "wr_rsp_count" : "rd_rsp_count", rv_n, 1);
        chk(wr ? "wr_addr" : "rd_addr", adr_bad, 0);
        chk(wr ? "wr_data_bus" : "rd_data_bus", dat_bad, 0);
        chk(wr ? "wr_drive_en" : "rd_drive_en", drv_bad, 0);
    endtask

    task automatic b2b();
        int acc = 0, gap = 0, gap_final = -1, busy_rdy = 0, cs_lo = 0;
        bit saw_low = 1'b0;
        m1.req_valid = 1'b1;
        m1.req_write = 1'b1;
        m1.req_addr  = 2'b11;
        m1.req_wdata = 16'h5A5A;
        for (int k = 0; k < 30; k++) begin
            if (m1.req_ready && m1.busy) busy_rdy++;
            if (m1.req_ready == m1.busy) busy_rdy++;
            if (acc == 2) m1.req_valid = 1'b0;
            else if (m1.req_valid && m1.req_ready) begin
                acc++;
                sb1.push_back(last1);
            end
            if (!cs_n1) begin
                cs_lo++;
                if (saw_low && gap > 0 && gap_final < 0) gap_final = gap;
                saw_low = 1'b1;
                gap = 0;
            end else if (saw_low) gap++;
            @(negedge Clk);
        end
        chk("b2b_accepts", acc, 2);
        chk("b2b_cs_gap", gap_final, 2);
        chk("b2b_cs_total", cs_lo, 8);
        chk("b2b_ready_busy", busy_rdy, 0);
    endtask

    initial begin
        int cs_lo, wr_lo, rv_at, bad;
        Reset_N      = 1'b0;
        m1.req_valid = 1'b0;
        m1.req_write = 1'b0;
        m1.req_addr  = '0;
        m1.req_wdata = '0;
        m2.req_valid = 1'b0;
        m2.req_write = 1'b0;
        m2.req_addr  = '0;
        m2.req_wdata = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_otg_rst_n", rst_n1, 0);
        chk("rst_strobes", {cs_n1, rd_n1, wr_n1}, 3'b111);
        chk("rst_addr", otg_addr1, 0);
        chk("rst_rsp_valid", m1.rsp_valid, 0);
        chk("rst_rsp_rdata", m1.rsp_rdata, 0);
        chk("rst_ready", m1.req_ready, 0);
        chk("rst_busy", m1.busy, 1);
        chk("rst_drive_en", dut1.drive_en_q, 0);
        boot_seq();

        txn1(1'b1, 2'b10, 16'hA5C3);
        txn1(1'b0, 2'b01, 16'h1234);
        b2b();

        m1.req_valid = 1'b1;
        m1.req_write = 1'b1;
        m1.req_addr  = 2'b00;
        m1.req_wdata = 16'hBEEF;
        @(negedge Clk);
        m1.req_valid = 1'b0;
        @(negedge Clk);
        chk("abort_mid_strobe", wr_n1, 0);
        Reset_N = 1'b0;
        @(negedge Clk);
        chk("abort_strobes", {cs_n1, rd_n1, wr_n1}, 3'b111);
        chk("abort_drive_en", dut1.drive_en_q, 0);
        chk("abort_rsp_valid", m1.rsp_valid, 0);
        chk("abort_otg_rst_n", rst_n1, 0);
        chk("abort_rdata", m1.rsp_rdata, 0);
        last1 = 16'h0;
        @(negedge Clk);
        boot_seq();

        chk("w_ready", m2.req_ready, 1);
        m2.req_valid = 1'b1;
        m2.req_write = 1'b1;
        m2.req_addr  = 3'b101;
        m2.req_wdata = 32'hDEADBEEF;
        sb2.push_back(32'h0);
        @(negedge Clk);
        m2.req_valid = 1'b0;
        cs_lo = 0;
        wr_lo = 0;
        rv_at = 0;
        bad   = 0;
        for (int k = 1; k <= 13; k++) begin
            if (!cs_n2) cs_lo++;
            if (!wr_n2) begin
                wr_lo++;
                if (k < 3 || k > 7) bad++;
            end
            if (!rd_n2) bad++;
            if (m2.rsp_valid) rv_at = k;
            if (!cs_n2 && otg_data2 !== 32'hDEADBEEF) bad++;
            if (!cs_n2 && otg_addr2 != 3'b101) bad++;
            @(negedge Clk);
        end
        chk("w_cs_len", cs_lo, 10);
        chk("w_wr_len", wr_lo, 5);
        chk("w_rsp_at", rv_at, 11);
        chk("w_bus_bad", bad, 0);

        repeat (3) @(negedge Clk);
        chk("sb1_drained", sb1.size(), 0);
        chk("sb2_drained", sb2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
